// File: rtl/uart_buffer_pkg.sv
// Shared types and constants for the uart_buffer slice.
package uart_buffer_pkg;

    localparam int unsigned DATA_W = 8;

    // TX drain FSM states; T_BUSY is a reserved encoding that recovers to T_IDLE.
    typedef enum logic [1:0] {
        T_IDLE  = 2'd0,
        T_START = 2'd1,
        T_BUSY  = 2'd2,
        T_WAIT  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/uart_buffer_sync_fifo.sv
// Synchronous FIFO with registered count and first-word fall-through head.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo
    import uart_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4,
    parameter int unsigned WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // Head is forced to zero while empty so the port reads 0 out of reset.
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Pointer and count update; pointers wrap naturally at DEPTH = 2**AW.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_buffer.sv
// Byte buffering between the CPU bus and the uart controller: a TX FIFO drained
// into the uart transmitter and an RX FIFO filled from the uart receiver.
module uart_buffer
    import uart_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tx_we,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_full,
    output logic              tx_idle,
    input  logic              rx_re,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_empty,
    output logic              irq,
    output logic              uart_we,
    output logic [DATA_W-1:0] uart_din,
    input  logic              uart_empty,
    output logic              uart_re,
    input  logic [DATA_W-1:0] uart_dout,
    input  logic              uart_full
);

    tx_state_t         state;
    tx_state_t         state_nxt;
    logic              tx_pop;
    logic              tx_empty;
    logic [DATA_W-1:0] tx_head;
    logic [AW:0]       tx_cnt;
    logic              rx_cap;
    logic              rx_full;
    logic [AW:0]       rx_cnt;

    sync_fifo #(.DEPTH(DEPTH), .AW(AW), .WIDTH(DATA_W)) u_tx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (tx_we),
        .din   (tx_data),
        .pop   (tx_pop),
        .dout  (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_cnt)
    );

    sync_fifo #(.DEPTH(DEPTH), .AW(AW), .WIDTH(DATA_W)) u_rx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rx_cap),
        .din   (uart_dout),
        .pop   (rx_re),
        .dout  (rx_data),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_cnt)
    );

    // Drain FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= T_IDLE;
        else        state <= state_nxt;
    end

    // Drain FSM next state: launch, wait for uart to go busy, wait for it to finish.
    always_comb begin
        state_nxt = state;
        case (state)
            T_IDLE:  if (!tx_empty && uart_empty) state_nxt = T_START;
            T_START: if (!uart_empty)             state_nxt = T_WAIT;
            T_WAIT:  if (uart_empty)              state_nxt = T_IDLE;
            default:                              state_nxt = T_IDLE;
        endcase
    end

    // Drain FSM outputs: pop the TX head when a launch is decided.
    always_comb begin
        tx_pop = 1'b0;
        if (state == T_IDLE && !tx_empty && uart_empty) tx_pop = 1'b1;
    end

    // uart_we/uart_din are registered, so uart_din holds the byte until the next pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uart_we  <= 1'b0;
            uart_din <= '0;
        end else begin
            uart_we <= tx_pop;
            if (tx_pop) uart_din <= tx_head;
        end
    end

    // The !uart_re term keeps the byte from being pushed twice while the uart clears full.
    assign rx_cap = uart_full && !rx_full && !uart_re;

    // One-cycle receiver acknowledge for each captured byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) uart_re <= 1'b0;
        else        uart_re <= rx_cap;
    end

    assign tx_idle = (tx_cnt == '0) && (state == T_IDLE) && uart_empty;
    assign irq     = (rx_cnt != '0);

endmodule

// File: tb/tb_uart_buffer.sv
// Directed bench for uart_buffer with a small behavioural uart on the far side.
module tb_uart_buffer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx_we = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_full;
    logic       tx_idle;
    logic       rx_re = 1'b0;
    logic [7:0] rx_data;
    logic       rx_empty;
    logic       irq;
    logic       uart_we;
    logic [7:0] uart_din;
    logic       uart_empty;
    logic       uart_re;
    logic [7:0] uart_dout;
    logic       uart_full;

    uart_buffer #(.DEPTH(16), .AW(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_we      (tx_we),
        .tx_data    (tx_data),
        .tx_full    (tx_full),
        .tx_idle    (tx_idle),
        .rx_re      (rx_re),
        .rx_data    (rx_data),
        .rx_empty   (rx_empty),
        .irq        (irq),
        .uart_we    (uart_we),
        .uart_din   (uart_din),
        .uart_empty (uart_empty),
        .uart_re    (uart_re),
        .uart_dout  (uart_dout),
        .uart_full  (uart_full)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // uart model state
    logic [7:0] tx_log[$];
    logic [7:0] rx_bytes[$];
    int         we_busy_err = 0;
    int         busy = 0;
    int         re_cnt = 0;
    int         rx_taken = 0;
    int         rx_sent = 0;
    logic       hold = 1'b0;

    // Behavioural uart: transmitter busy for 6 cycles per byte, receiver presents queued bytes.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uart_empty <= 1'b1;
            busy       <= 0;
            uart_full  <= 1'b0;
            uart_dout  <= 8'h00;
        end else begin
            if (uart_we) begin
                if (!uart_empty) we_busy_err <= we_busy_err + 1;
                tx_log.push_back(uart_din);
                uart_empty <= 1'b0;
                busy       <= 6;
            end else if (busy > 0) begin
                busy <= busy - 1;
                if (busy == 1) uart_empty <= 1'b1;
            end else if (hold) begin
                uart_empty <= 1'b0;
            end else begin
                uart_empty <= 1'b1;
            end
            if (uart_re) begin
                re_cnt    <= re_cnt + 1;
                uart_full <= 1'b0;
            end else if (!uart_full && rx_taken != rx_sent) begin
                uart_full <= 1'b1;
                uart_dout <= rx_bytes[rx_taken];
                rx_taken  <= rx_taken + 1;
            end
        end
    end

    task automatic push_tx(input logic [7:0] b);
        tx_data = b;
        tx_we   = 1'b1;
        @(negedge clk);
        tx_we   = 1'b0;
    endtask

    task automatic pop_rx();
        rx_re = 1'b1;
        @(negedge clk);
        rx_re = 1'b0;
    endtask

    task automatic rx_present(input logic [7:0] b);
        rx_bytes.push_back(b);
        rx_sent++;
    endtask

    task automatic rx_send_wait(input logic [7:0] b);
        int n = 0;
        rx_present(b);
        do begin
            @(negedge clk);
            n++;
        end while ((rx_taken != rx_sent || uart_full || uart_re) && n < 20);
        check_eq("rx_send_done", 32'(n < 20), 1);
    endtask

    task automatic wait_idle(input string tag, input int max_cyc);
        int n = 0;
        while (!tx_idle && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, 32'(tx_idle), 1);
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, "_tx_full"},  32'(tx_full), 0);
        check_eq({tag, "_tx_idle"},  32'(tx_idle), 1);
        check_eq({tag, "_rx_empty"}, 32'(rx_empty), 1);
        check_eq({tag, "_irq"},      32'(irq), 0);
        check_eq({tag, "_rx_data"},  32'(rx_data), 0);
        check_eq({tag, "_uart_we"},  32'(uart_we), 0);
        check_eq({tag, "_uart_re"},  32'(uart_re), 0);
        check_eq({tag, "_uart_din"}, 32'(uart_din), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base;
        int rb;
        int n;

        repeat (3) @(negedge clk);
        check_reset("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // 1: single byte, uart_we two cycles after the push
        base = tx_log.size();
        tx_data = 8'h55;
        tx_we   = 1'b1;
        @(negedge clk);
        tx_we = 1'b0;
        check_eq("t1_we_n1", 32'(uart_we), 0);
        @(negedge clk);
        check_eq("t1_we_n2", 32'(uart_we), 1);
        check_eq("t1_din_n2", 32'(uart_din), 'h55);
        @(negedge clk);
        check_eq("t1_we_n3", 32'(uart_we), 0);
        wait_idle("t1_idle", 50);
        check_eq("t1_log_size", 32'(tx_log.size() - base), 1);
        check_eq("t1_log_byte", 32'(tx_log[base]), 'h55);
        check_eq("t1_din_held", 32'(uart_din), 'h55);

        // 2: fill TX FIFO while uart busy, overflow byte dropped, drain in order
        base = tx_log.size();
        hold = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 1; i <= 16; i++) push_tx(8'(i));
        check_eq("t2_full", 32'(tx_full), 1);
        push_tx(8'hFF);
        check_eq("t2_full_after_drop", 32'(tx_full), 1);
        check_eq("t2_no_we_while_held", 32'(tx_log.size() - base), 0);
        hold = 1'b0;
        wait_idle("t2_idle", 400);
        check_eq("t2_log_size", 32'(tx_log.size() - base), 16);
        for (int i = 0; i < 16; i++) check_eq("t2_order", 32'(tx_log[base + i]), 32'(i + 1));
        check_eq("t2_not_full", 32'(tx_full), 0);

        // 3: single RX byte capture and pop
        rb = re_cnt;
        rx_present(8'hA5);
        @(negedge clk);
        check_eq("t3_empty_before", 32'(rx_empty), 1);
        @(negedge clk);
        check_eq("t3_rx_empty", 32'(rx_empty), 0);
        check_eq("t3_irq", 32'(irq), 1);
        check_eq("t3_rx_data", 32'(rx_data), 'hA5);
        check_eq("t3_uart_re", 32'(uart_re), 1);
        @(negedge clk);
        check_eq("t3_uart_re_low", 32'(uart_re), 0);
        repeat (3) @(negedge clk);
        check_eq("t3_re_pulses", 32'(re_cnt - rb), 1);
        pop_rx();
        check_eq("t3_rx_empty_after", 32'(rx_empty), 1);
        check_eq("t3_irq_after", 32'(irq), 0);

        // 4: fill RX FIFO, backpressure, resume after one pop
        rb = re_cnt;
        for (int i = 0; i < 16; i++) rx_send_wait(8'(8'h80 + i));
        check_eq("t4_re_16", 32'(re_cnt - rb), 16);
        check_eq("t4_head", 32'(rx_data), 'h80);
        rx_present(8'h3C);
        repeat (10) @(negedge clk);
        check_eq("t4_no_ack_full", 32'(re_cnt - rb), 16);
        check_eq("t4_uart_re_low", 32'(uart_re), 0);
        pop_rx();
        n = 0;
        while (re_cnt - rb != 17 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check_eq("t4_ack_resumed", 32'(re_cnt - rb), 17);
        for (int i = 1; i < 16; i++) begin
            check_eq("t4_rx_order", 32'(rx_data), 32'(8'h80 + i));
            pop_rx();
        end
        check_eq("t4_rx_last", 32'(rx_data), 'h3C);
        pop_rx();
        check_eq("t4_rx_empty", 32'(rx_empty), 1);

        // 5a: push on full TX FIFO in the same cycle as the drain pop
        base = tx_log.size();
        hold = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 16; i++) push_tx(8'(8'h20 + i));
        check_eq("t5_full", 32'(tx_full), 1);
        hold = 1'b0;
        @(negedge clk);
        tx_data = 8'h77;
        tx_we   = 1'b1;
        @(negedge clk);
        tx_we = 1'b0;
        check_eq("t5_still_full", 32'(tx_full), 1);
        check_eq("t5_we", 32'(uart_we), 1);
        check_eq("t5_din", 32'(uart_din), 'h20);
        wait_idle("t5_idle", 400);
        check_eq("t5_log_size", 32'(tx_log.size() - base), 17);
        for (int i = 0; i < 16; i++) check_eq("t5_order", 32'(tx_log[base + i]), 32'(8'h20 + i));
        check_eq("t5_last", 32'(tx_log[base + 16]), 'h77);

        // 5b: pop on empty RX FIFO in the same cycle as a capture
        rb = re_cnt;
        rx_present(8'h6E);
        @(negedge clk);
        rx_re = 1'b1;
        @(negedge clk);
        rx_re = 1'b0;
        check_eq("t5_rx_count1", 32'(rx_empty), 0);
        check_eq("t5_rx_data", 32'(rx_data), 'h6E);
        pop_rx();
        check_eq("t5_rx_empty", 32'(rx_empty), 1);
        repeat (3) @(negedge clk);
        check_eq("t5_re_pulses", 32'(re_cnt - rb), 1);

        // 6: reset while in T_WAIT with 3 bytes queued
        base = tx_log.size();
        push_tx(8'hC1);
        push_tx(8'hC2);
        push_tx(8'hC3);
        push_tx(8'hC4);
        check_eq("t6_one_sent", 32'(tx_log.size() - base), 1);
        check_eq("t6_busy", 32'(tx_idle), 0);
        rst_n = 1'b0;
        #1;
        check_reset("t6_rst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check_eq("t6_no_we_after", 32'(tx_log.size() - base), 1);
        check_eq("t6_idle", 32'(tx_idle), 1);
        push_tx(8'h99);
        wait_idle("t6_idle2", 50);
        check_eq("t6_log_size", 32'(tx_log.size() - base), 2);
        check_eq("t6_new_byte", 32'(tx_log[base + 1]), 'h99);
        check_eq("we_while_busy", 32'(we_busy_err), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
